// File: rtl/calc1_core.sv
// Four-port unsigned 32-bit calculator. One shared ADD unit and one shared
// SHIFT unit, each granted to the lowest-numbered pending port every cycle.
module calc1_core (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp4
);

  typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_PEND, ST_INV} port_state_t;

  port_state_t state      [4];
  port_state_t next_state [4];

  logic [3:0]  cmd_in  [4];
  logic [31:0] data_in [4];
  logic [3:0]  cmd_q   [4];
  logic [31:0] op1_q   [4];
  logic [31:0] op2_q   [4];
  logic [1:0]  resp_q  [4];
  logic [31:0] data_q  [4];

  logic [3:0]  add_grant;
  logic [3:0]  shift_grant;
  logic [1:0]  add_sel;
  logic [1:0]  shift_sel;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [32:0] add_sum;
  logic [1:0]  add_resp;
  logic [31:0] add_data;
  logic [31:0] shift_a;
  logic [31:0] shift_b;
  logic [31:0] shift_data;

  // The big-endian port ranges keep their numeric value when copied into
  // conventional little-endian vectors, so the core works on [N:0] values.
  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  assign out_data1 = data_q[0];
  assign out_resp1 = resp_q[0];
  assign out_data2 = data_q[1];
  assign out_resp2 = resp_q[1];
  assign out_data3 = data_q[2];
  assign out_resp3 = resp_q[2];
  assign out_data4 = data_q[3];
  assign out_resp4 = resp_q[3];

  function automatic logic is_add(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2);
  endfunction

  function automatic logic is_shift(input logic [3:0] c);
    return (c == 4'd5) || (c == 4'd6);
  endfunction

  // Scanning from port 4 down lets the lowest pending port overwrite the grant.
  always_comb begin
    add_grant   = '0;
    shift_grant = '0;
    add_sel     = 2'd0;
    shift_sel   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (state[i] == ST_PEND && is_add(cmd_q[i])) begin
        add_grant = 4'b0001 << i;
        add_sel   = 2'(i);
      end
      if (state[i] == ST_PEND && is_shift(cmd_q[i])) begin
        shift_grant = 4'b0001 << i;
        shift_sel   = 2'(i);
      end
    end
  end

  always_comb begin
    add_a    = op1_q[add_sel];
    add_b    = op2_q[add_sel];
    add_sum  = {1'b0, add_a} + {1'b0, add_b};
    add_resp = 2'd1;
    add_data = 32'd0;
    if (cmd_q[add_sel] == 4'd1) begin
      if (add_sum[32]) add_resp = 2'd2;
      else             add_data = add_sum[31:0];
    end else begin
      if (add_b > add_a) add_resp = 2'd2;
      else               add_data = add_a - add_b;
    end
  end

  always_comb begin
    shift_a = op1_q[shift_sel];
    shift_b = op2_q[shift_sel];
    if (cmd_q[shift_sel] == 4'd5) shift_data = shift_a << shift_b[4:0];
    else                          shift_data = shift_a >> shift_b[4:0];
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      next_state[i] = state[i];
      case (state[i])
        ST_IDLE: begin
          if (cmd_in[i] != 4'd0)
            next_state[i] = (is_add(cmd_in[i]) || is_shift(cmd_in[i])) ? ST_OP2 : ST_INV;
        end
        ST_OP2:  next_state[i] = ST_PEND;
        ST_PEND: if (add_grant[i] || shift_grant[i]) next_state[i] = ST_IDLE;
        ST_INV:  next_state[i] = ST_IDLE;
        default: next_state[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) state[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < 4; i++) state[i] <= next_state[i];
    end
  end

  // Responses default back to 0/0 so each one is visible for exactly a cycle.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        cmd_q[i]  <= 4'd0;
        op1_q[i]  <= 32'd0;
        op2_q[i]  <= 32'd0;
        resp_q[i] <= 2'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        resp_q[i] <= 2'd0;
        data_q[i] <= 32'd0;
        if (state[i] == ST_IDLE && cmd_in[i] != 4'd0) begin
          cmd_q[i] <= cmd_in[i];
          op1_q[i] <= data_in[i];
        end
        if (state[i] == ST_OP2) op2_q[i] <= data_in[i];
        if (state[i] == ST_INV) begin
          resp_q[i] <= 2'd2;
        end else if (add_grant[i]) begin
          resp_q[i] <= add_resp;
          data_q[i] <= add_data;
        end else if (shift_grant[i]) begin
          resp_q[i] <= 2'd1;
          data_q[i] <= shift_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc1_core.sv
// Randomized and directed bench for calc1_core: stimulus pushes expected
// responses per port; a monitor pops and compares whenever a response appears.
module tb_calc1_core;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  cmd_drv  [4];
  logic [31:0] data_drv [4];
  logic [0:31] out_data1, out_data2, out_data3, out_data4;
  logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [1:0]  resp_obs [4];
  logic [31:0] data_obs [4];

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q [4][$];
  int   errors    = 0;
  int   checks    = 0;
  int   cycle_cnt = 0;

  calc1_core dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd_drv[0]),
    .req1_data_in (data_drv[0]),
    .req2_cmd_in  (cmd_drv[1]),
    .req2_data_in (data_drv[1]),
    .req3_cmd_in  (cmd_drv[2]),
    .req3_data_in (data_drv[2]),
    .req4_cmd_in  (cmd_drv[3]),
    .req4_data_in (data_drv[3]),
    .out_data1    (out_data1),
    .out_resp1    (out_resp1),
    .out_data2    (out_data2),
    .out_resp2    (out_resp2),
    .out_data3    (out_data3),
    .out_resp3    (out_resp3),
    .out_data4    (out_data4),
    .out_resp4    (out_resp4)
  );

  assign resp_obs[0] = out_resp1;
  assign resp_obs[1] = out_resp2;
  assign resp_obs[2] = out_resp3;
  assign resp_obs[3] = out_resp4;
  assign data_obs[0] = out_data1;
  assign data_obs[1] = out_data2;
  assign data_obs[2] = out_data3;
  assign data_obs[3] = out_data4;

  initial forever #5 c_clk = ~c_clk;

  always @(posedge c_clk) cycle_cnt <= cycle_cnt + 1;

  // Reference behaviour straight from the arithmetic rules.
  function automatic exp_t model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint s;
    e.resp = 2'd1;
    e.data = 32'd0;
    e.cyc  = -1;
    case (cmd)
      4'd1: begin
        s = longint'(a) + longint'(b);
        if (s > 64'h0000_0000_FFFF_FFFF) e.resp = 2'd2;
        else e.data = a + b;
      end
      4'd2: begin
        if (b > a) e.resp = 2'd2;
        else e.data = a - b;
      end
      4'd5: e.data = a << (b % 32);
      4'd6: e.data = a >> (b % 32);
      default: e.resp = 2'd2;
    endcase
    return e;
  endfunction

  // Issue one command on port p; extra<0 means arrival cycle is not checked,
  // otherwise the response is expected 'extra' cycles after the minimum latency.
  task automatic applyStimulus(input int p, input logic [3:0] cmd, input logic [31:0] a,
                               input logic [31:0] b, input int extra);
    exp_t e;
    logic valid;
    valid = (cmd == 4'd1) || (cmd == 4'd2) || (cmd == 4'd5) || (cmd == 4'd6);
    @(posedge c_clk); #2;
    e = model(cmd, a, b);
    e.cyc = (extra < 0) ? -1 : cycle_cnt + (valid ? 3 : 2) + extra;
    exp_q[p].push_back(e);
    cmd_drv[p]  = cmd;
    data_drv[p] = a;
    @(posedge c_clk); #2;
    if (valid) begin
      cmd_drv[p]  = 4'($urandom_range(1, 15));
      data_drv[p] = b;
      @(posedge c_clk); #2;
    end
    cmd_drv[p]  = 4'd0;
    data_drv[p] = $urandom;
  endtask

  task automatic waitIdle(input int p);
    int n = 0;
    while (exp_q[p].size() != 0 && n < 60) begin
      @(posedge c_clk); #3;
      n++;
    end
    checks++;
    if (exp_q[p].size() != 0) begin
      errors++;
      $display("[TB] FAIL timeout port%0d: %0d responses outstanding, required 0", p + 1, exp_q[p].size());
      exp_q[p].delete();
    end
  endtask

  task automatic randomPort(input int p, input int count);
    logic [3:0]  cmd;
    logic [31:0] a, b;
    logic [3:0]  cmd_tab [4];
    cmd_tab[0] = 4'd1; cmd_tab[1] = 4'd2; cmd_tab[2] = 4'd5; cmd_tab[3] = 4'd6;
    for (int k = 0; k < count; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        cmd = 4'($urandom_range(3, 15));
        if (cmd == 4'd5 || cmd == 4'd6) cmd = 4'd4;
      end else begin
        cmd = cmd_tab[$urandom_range(0, 3)];
      end
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      applyStimulus(p, cmd, a, b, -1);
      waitIdle(p);
      repeat ($urandom_range(0, 2)) @(posedge c_clk);
    end
  endtask

  task automatic checkOutput(input int p);
    exp_t e;
    checks++;
    if (resp_obs[p] == 2'd0) begin
      if (data_obs[p] != 32'd0) begin
        errors++;
        $display("[TB] FAIL idle_data port%0d: got data=%h with resp=0, required 0", p + 1, data_obs[p]);
      end
    end else if (exp_q[p].size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected port%0d: got resp=%0d data=%h, required no response",
               p + 1, resp_obs[p], data_obs[p]);
    end else begin
      e = exp_q[p].pop_front();
      if (resp_obs[p] !== e.resp || data_obs[p] !== e.data) begin
        errors++;
        $display("[TB] FAIL result port%0d: got resp=%0d data=%h, required resp=%0d data=%h",
                 p + 1, resp_obs[p], data_obs[p], e.resp, e.data);
      end
      if (e.cyc >= 0) begin
        checks++;
        if (cycle_cnt != e.cyc) begin
          errors++;
          $display("[TB] FAIL latency port%0d: response at cycle %0d, required cycle %0d",
                   p + 1, cycle_cnt, e.cyc);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge c_clk); #1;
      for (int p = 0; p < 4; p++) checkOutput(p);
    end
  end

  initial begin
    logic [31:0] x;
    reset = 1'b0;
    for (int p = 0; p < 4; p++) begin
      cmd_drv[p]  = 4'd1;
      data_drv[p] = 32'hDEAD_BEEF;
    end
    repeat (4) @(posedge c_clk);
    #2;
    for (int p = 0; p < 4; p++) cmd_drv[p] = 4'd0;
    reset = 1'b1;
    repeat (3) @(posedge c_clk);

    $display("[TB] directed arithmetic");
    applyStimulus(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 0); waitIdle(0);
    applyStimulus(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 0); waitIdle(0);
    applyStimulus(0, 4'd1, 32'h0, 32'h0, 0);                 waitIdle(0);
    applyStimulus(0, 4'd1, 32'hFFFF_FFFF, 32'h1, 0);         waitIdle(0);
    applyStimulus(0, 4'd2, 32'd1, 32'd15, 0);                waitIdle(0);
    applyStimulus(0, 4'd2, 32'd15, 32'd1, 0);                waitIdle(0);
    applyStimulus(0, 4'd2, 32'd77, 32'd77, 0);               waitIdle(0);
    applyStimulus(0, 4'd3, 32'h1234, 32'h0, 0);              waitIdle(0);
    applyStimulus(0, 4'd4, 32'h1234, 32'h0, 0);              waitIdle(0);
    applyStimulus(0, 4'd15, 32'h1234, 32'h0, 0);             waitIdle(0);

    $display("[TB] invalid command held two cycles");
    @(posedge c_clk); #2;
    begin
      exp_t e;
      e = model(4'd3, 32'd0, 32'd0);
      e.cyc = cycle_cnt + 2;
      exp_q[0].push_back(e);
    end
    cmd_drv[0] = 4'd3;
    @(posedge c_clk); #2;
    @(posedge c_clk); #2;
    cmd_drv[0] = 4'd0;
    waitIdle(0);
    repeat (3) @(posedge c_clk);

    $display("[TB] walking-one sweep");
    for (int i = 0; i < 31; i++) begin
      x = 32'd1 << i;
      applyStimulus(0, 4'd1, x, 32'd0, 0);  waitIdle(0);
      applyStimulus(0, 4'd5, x, 32'd1, 0);  waitIdle(0);
      applyStimulus(0, 4'd5, x, 32'd33, 0); waitIdle(0);
      applyStimulus(0, 4'd6, x, 32'd33, 0); waitIdle(0);
    end
    applyStimulus(0, 4'd6, 32'h8000_0000, 32'd31, 0); waitIdle(0);

    $display("[TB] contention");
    fork
      applyStimulus(0, 4'd1, 32'd10, 32'd20, 0);
      applyStimulus(1, 4'd1, 32'd30, 32'd40, 1);
      applyStimulus(2, 4'd2, 32'd500, 32'd60, 2);
      begin
        applyStimulus(3, 4'd1, 32'hFFFF_FFF0, 32'h20, 3);
        cmd_drv[3]  = 4'd2;
        data_drv[3] = $urandom;
        repeat (3) @(posedge c_clk);
        #2 cmd_drv[3] = 4'd0;
      end
    join
    for (int p = 0; p < 4; p++) waitIdle(p);
    repeat (2) @(posedge c_clk);

    fork
      applyStimulus(0, 4'd1, 32'h0100_0000, 32'h0000_00FF, 0);
      applyStimulus(1, 4'd5, 32'h0000_00F1, 32'd4, 0);
    join
    waitIdle(0);
    waitIdle(1);

    $display("[TB] reset mid-operation");
    @(posedge c_clk); #2;
    cmd_drv[0]  = 4'd1;
    data_drv[0] = 32'd5;
    cmd_drv[1]  = 4'd6;
    data_drv[1] = 32'h100;
    @(posedge c_clk); #2;
    cmd_drv[0]  = 4'd0;
    data_drv[0] = 32'd7;
    cmd_drv[1]  = 4'd0;
    data_drv[1] = 32'd2;
    #3 reset = 1'b0;
    repeat (2) @(posedge c_clk);
    #2 reset = 1'b1;
    repeat (4) @(posedge c_clk);
    applyStimulus(0, 4'd2, 32'd100, 32'd1, 0); waitIdle(0);

    $display("[TB] randomized traffic");
    fork
      randomPort(0, 40);
      randomPort(1, 40);
      randomPort(2, 40);
      randomPort(3, 40);
    join
    repeat (5) @(posedge c_clk);

    for (int p = 0; p < 4; p++) begin
      checks++;
      if (exp_q[p].size() != 0) begin
        errors++;
        $display("[TB] FAIL leftover port%0d: %0d responses outstanding, required 0", p + 1, exp_q[p].size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
